regfile_wb_queue: RTL and testbench
===================================

// Module: regfile_wb_queue
// PURPOSE
//  Write-side producer for the 32x32 register file: buffers writeback requests (rd, data)
//  from the execute/load paths in a small FIFO and drains one per cycle onto the register
//  file write port (wr_en/wr_rd/wr_data; register file commits on negedge clk).
//  Provides youngest-first bypass lookup for two read addresses so readers see pending writes.
// PARAMETERS
//  XLEN   32  data width
//  REG_AW 5   register address width (x0..x31)
//  DEPTH  4   FIFO entries; power of 2, >=2
// PORTS
//  clk        in  1             clock, all state on posedge
//  reset_n    in  1             asynchronous, active-low reset
//  flush      in  1             sync clear of all pending writes
//  drain_en   in  1             1 = head may pop this cycle; 0 = hold writes
//  in_valid   in  1             writeback request valid
//  in_ready   out 1             request accepted when in_valid&&in_ready at posedge
//  in_rd      in  REG_AW        destination register
//  in_data    in  XLEN          write data
//  wr_en      out 1             register-file write enable (registered)
//  wr_rd      out REG_AW        register-file write address (registered)
//  wr_data    out XLEN          register-file write data (registered)
//  rs1, rs2   in  REG_AW        bypass lookup addresses
//  byp1_hit   out 1             pending write to rs1 exists
//  byp1_data  out XLEN          youngest pending data for rs1 (0 when no hit)
//  byp2_hit   out 1             as byp1 for rs2
//  byp2_data  out XLEN          as byp1 for rs2
//  count      out $clog2(DEPTH+1) FIFO occupancy (excludes output register)
// BEHAVIOUR
//  Reset (reset_n=0, async): pointers, count=0, wr_en=0, wr_rd=0, wr_data=0; pending writes
//   discarded; in_ready=0 while reset_n=0; byp*_hit=0.
//  in_ready = reset_n && !flush && (count < DEPTH); no combinational path from drain_en.
//  Push: accepted request with in_rd!=0 enqueued at tail; in_rd==0 accepted and dropped.
//  Pop: at posedge, if count>0 && drain_en && !flush: head -> {wr_en=1,wr_rd,wr_data}, head++.
//   Otherwise wr_en<=0 (wr_rd/wr_data hold last value).
//  Latency: accept at edge N into empty queue -> wr_en=1 during cycle after edge N+1;
//   one write per cycle max; throughput 1/cycle with simultaneous push+pop.
//  Simultaneous push+pop: count unchanged; push+pop when full impossible (in_ready=0).
//  Wrap-around: pointers are log2(DEPTH) bits, wrap naturally; count disambiguates full/empty.
//  Ordering: writes drain strictly in acceptance order; same rd twice -> both written, last wins.
//  Bypass (combinational): search FIFO entries youngest->oldest, then output register if wr_en=1;
//   first match gives hit=1,data. rs==0 -> hit=0,data=0. Same-cycle in_* not searched.
//  flush: at posedge, count<=0, pointers reset, wr_en<=0; a push in the same cycle is refused
//   (in_ready=0). Reset mid-drain: in-flight wr_en cleared immediately (async).
// STRUCTURE
//  Package regfile_pkg: XLEN, REG_AW, wb_entry_t struct {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;}.
//  Sub-module regfile_bypass_match: combinational priority search of entry array by age,
//   instantiated twice (rs1, rs2). FIFO storage/pointers inline in regfile_wb_queue.
// TESTING
//  1. Reset, push (rd=5,data=0x1234), drain_en=1 -> wr_en=1,wr_rd=5,wr_data=0x1234 one cycle later.
//  2. drain_en=0, push rd=1..4 -> count=4, in_ready=0; 5th request stalls; drain_en=1 -> 4 writes in order.
//  3. Push rd=7 data=0xA then rd=7 data=0xB, drain_en=0, rs1=7 -> byp1_hit=1, byp1_data=0xB; rs2=0 -> hit=0.
//  4. Push in_rd=0 data=0xFFFFFFFF -> accepted, count stays 0, no wr_en pulse.
//  5. Queue holds 3 entries, flush=1 with in_valid=1 -> count=0, wr_en=0 next cycle, push refused.
//  6. reset_n low mid-drain (count=2, wr_en=1) -> wr_en=0, count=0 immediately; 10 push/pop wraps keep order.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and the writeback entry type used by the register-file writeback queue.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_bypass_match.sv
// Priority search of the pending writebacks for one read address; the youngest matching write wins.
module regfile_bypass_match
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [REG_AW-1:0] rs,
  input  wb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  entry_valid,
  input  logic              out_valid,
  input  wb_entry_t         out_entry,
  output logic              hit,
  output logic [XLEN-1:0]   data
);

  // entries[] is ordered oldest first, so later matches overwrite earlier ones; the output
  // register is older than anything still queued and is therefore checked first.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (rs != '0) begin
      if (out_valid && (out_entry.rd == rs)) begin
        hit  = 1'b1;
        data = out_entry.data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_valid[i] && (entries[i].rd == rs)) begin
          hit  = 1'b1;
          data = entries[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback FIFO feeding the register-file write port one entry per cycle, with bypass lookup
// on two read addresses so readers observe writes that have not yet been committed.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              drain_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_data,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_rd,
  output logic [XLEN-1:0]   wr_data,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              byp1_hit,
  output logic [XLEN-1:0]   byp1_data,
  output logic              byp2_hit,
  output logic [XLEN-1:0]   byp2_data,
  output logic [CNT_W-1:0]  count
);

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   head_reg, tail_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               wr_en_reg;
  logic [REG_AW-1:0]  wr_rd_reg;
  logic [XLEN-1:0]    wr_data_reg;

  logic push, push_store, pop;

  assign in_ready   = reset_n && !flush && (count_reg < CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  // Writes to x0 are accepted to keep the producer moving but never occupy a slot.
  assign push_store = push && (in_rd != '0);
  assign pop        = (count_reg != '0) && drain_en && !flush;

  always_comb begin
    count_next = count_reg + CNT_W'(push_store) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_rd_reg   <= '0;
      wr_data_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      wr_en_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push_store) tail_reg <= tail_reg + PTR_W'(1);
      if (pop) begin
        head_reg    <= head_reg + PTR_W'(1);
        wr_en_reg   <= 1'b1;
        wr_rd_reg   <= mem[head_reg].rd;
        wr_data_reg <= mem[head_reg].data;
      end else begin
        wr_en_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_store) mem[tail_reg] <= '{rd: in_rd, data: in_data};
  end

  // Present the queue to the matchers oldest first, with validity derived from occupancy.
  wb_entry_t        age_entries [DEPTH];
  logic [DEPTH-1:0] age_valid;
  wb_entry_t        out_entry;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_entries[gi] = mem[head_reg + PTR_W'(gi)];
      assign age_valid[gi]   = CNT_W'(gi) < count_reg;
    end
  endgenerate

  assign out_entry = '{rd: wr_rd_reg, data: wr_data_reg};

  regfile_bypass_match #(.DEPTH(DEPTH)) u_byp1 (
    .rs          (rs1),
    .entries     (age_entries),
    .entry_valid (age_valid),
    .out_valid   (wr_en_reg),
    .out_entry   (out_entry),
    .hit         (byp1_hit),
    .data        (byp1_data)
  );

  regfile_bypass_match #(.DEPTH(DEPTH)) u_byp2 (
    .rs          (rs2),
    .entries     (age_entries),
    .entry_valid (age_valid),
    .out_valid   (wr_en_reg),
    .out_entry   (out_entry),
    .hit         (byp2_hit),
    .data        (byp2_data)
  );

  assign wr_en   = wr_en_reg;
  assign wr_rd   = wr_rd_reg;
  assign wr_data = wr_data_reg;
  assign count   = count_reg;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for the writeback queue: latency, fill/stall, bypass priority, x0 drop, flush, reset, wrap.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush, drain_en, in_valid, in_ready;
  logic [4:0]  in_rd, wr_rd, rs1, rs2;
  logic [31:0] in_data, wr_data, byp1_data, byp2_data;
  logic        wr_en, byp1_hit, byp2_hit;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .drain_en  (drain_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .wr_rd     (wr_rd),
    .wr_data   (wr_data),
    .rs1       (rs1),
    .rs2       (rs2),
    .byp1_hit  (byp1_hit),
    .byp1_data (byp1_data),
    .byp2_hit  (byp2_hit),
    .byp2_data (byp2_data),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] rd,
                        input logic [31:0] data, input logic [2:0] cnt);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(en));
    chk({tag, "_wr_rd"}, 64'(wr_rd), 64'(rd));
    chk({tag, "_wr_data"}, 64'(wr_data), 64'(data));
    chk({tag, "_count"}, 64'(count), 64'(cnt));
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; drain_en = 1'b0; in_valid = 1'b0;
    in_rd = '0; in_data = '0; rs1 = 5'd5; rs2 = 5'd0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk_wr("rst", 1'b0, 5'd0, 32'h0, 3'd0);
    chk("rst_byp1_hit", 64'(byp1_hit), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 1: single write latency
    in_valid = 1'b1; in_rd = 5'd5; in_data = 32'h1234; drain_en = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_wr("t1_accept", 1'b0, 5'd0, 32'h0, 3'd1);
    chk("t1_byp_q_hit", 64'(byp1_hit), 64'd1);
    chk("t1_byp_q_data", 64'(byp1_data), 64'h1234);
    tick();
    chk_wr("t1_write", 1'b1, 5'd5, 32'h1234, 3'd0);
    chk("t1_byp_out_hit", 64'(byp1_hit), 64'd1);
    tick();
    chk_wr("t1_idle", 1'b0, 5'd5, 32'h1234, 3'd0);
    chk("t1_byp_gone", 64'(byp1_hit), 64'd0);

    // 2: fill to DEPTH, stall, then drain in order
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h100 + 32'(i);
      tick();
    end
    in_rd = 5'd9; in_data = 32'h109;
    chk("t2_full_count", 64'(count), 64'd4);
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    tick();
    chk_wr("t2_stall", 1'b0, 5'd5, 32'h1234, 3'd4);
    in_valid = 1'b0; drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_wr($sformatf("t2_drain%0d", i), 1'b1, 5'(i), 32'h100 + 32'(i), 3'(4 - i));
    end
    tick();
    chk_wr("t2_done", 1'b0, 5'd4, 32'h104, 3'd0);

    // 3: youngest-first bypass
    drain_en = 1'b0;
    in_valid = 1'b1; in_rd = 5'd7; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    in_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd0;
    #1;
    chk("t3_byp1_hit", 64'(byp1_hit), 64'd1);
    chk("t3_byp1_data", 64'(byp1_data), 64'hB);
    chk("t3_byp2_hit_x0", 64'(byp2_hit), 64'd0);
    chk("t3_byp2_data_x0", 64'(byp2_data), 64'd0);
    rs2 = 5'd3;
    #1;
    chk("t3_byp2_miss", 64'(byp2_hit), 64'd0);
    drain_en = 1'b1;
    tick();
    chk_wr("t3_w1", 1'b1, 5'd7, 32'hA, 3'd1);
    chk("t3_byp_mixed", 64'(byp1_data), 64'hB);
    tick();
    chk_wr("t3_w2", 1'b1, 5'd7, 32'hB, 3'd0);
    chk("t3_byp_out", 64'(byp1_data), 64'hB);
    tick();
    chk_wr("t3_done", 1'b0, 5'd7, 32'hB, 3'd0);

    // 4: write to x0 accepted and dropped
    in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFFFF_FFFF;
    #1;
    chk("t4_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk_wr("t4_a", 1'b0, 5'd7, 32'hB, 3'd0);
    tick();
    chk_wr("t4_b", 1'b0, 5'd7, 32'hB, 3'd0);

    // 5: flush discards pending writes and refuses a same-cycle push
    drain_en = 1'b0;
    for (int i = 10; i <= 12; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h200 + 32'(i);
      tick();
    end
    chk("t5_count3", 64'(count), 64'd3);
    flush = 1'b1; in_rd = 5'd13; in_data = 32'h20D;
    #1;
    chk("t5_flush_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; drain_en = 1'b1; rs1 = 5'd10;
    #1;
    chk_wr("t5_flushed", 1'b0, 5'd7, 32'hB, 3'd0);
    chk("t5_byp_cleared", 64'(byp1_hit), 64'd0);
    tick();
    chk_wr("t5_no_write", 1'b0, 5'd7, 32'hB, 3'd0);

    // 6: async reset mid-drain, then wrap-around stream
    drain_en = 1'b0;
    for (int i = 20; i <= 22; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h300 + 32'(i);
      tick();
    end
    in_valid = 1'b0; drain_en = 1'b1;
    tick();
    chk_wr("t6_pre", 1'b1, 5'd20, 32'h314, 3'd2);
    reset_n = 1'b0;
    #1;
    chk_wr("t6_async", 1'b0, 5'd0, 32'h0, 3'd0);
    chk("t6_ready_low", 64'(in_ready), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_rd = 5'(k + 1); in_data = 32'hC00 + 32'(k);
      tick();
      if (k == 0) chk_wr("t6_wrap0", 1'b0, 5'd0, 32'h0, 3'd1);
      else chk_wr($sformatf("t6_wrap%0d", k), 1'b1, 5'(k), 32'hC00 + 32'(k - 1), 3'd1);
    end
    in_valid = 1'b0;
    tick();
    chk_wr("t6_last", 1'b1, 5'd10, 32'hC09, 3'd0);
    tick();
    chk_wr("t6_end", 1'b0, 5'd10, 32'hC09, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
